// File: rtl/random_pkg.sv
// Shared definitions for the multi-stream random generator: register offsets,
// ctrl bit positions, FSM states and the two generator step functions.
package random_pkg;

  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_SEL  = 3'd1;
  localparam logic [2:0] REG_Z    = 3'd2;
  localparam logic [2:0] REG_W    = 3'd3;
  localparam logic [2:0] REG_CTRL = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;

  localparam int CTRL_MODE   = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_REINIT = 2;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_ACK,
    S_WAIT
  } state_t;

  // 16x16 product plus a 16-bit carry always fits in 32 bits.
  function automatic logic [31:0] mwc_step(input logic [31:0] x, input logic [15:0] mul);
    return ({16'h0, mul} * {16'h0, x[15:0]}) + {16'h0, x[31:16]};
  endfunction

  function automatic logic [31:0] xs32_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [31:0] nonzero(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/rand_mstream_ram.sv
// Single-port block RAM holding one 32-bit state word per stream;
// synchronous write and registered read.
module rand_mstream_ram #(
  parameter int pAddrBits = 10
) (
  input  logic                 clk_i,
  input  logic [pAddrBits-1:0] addr,
  input  logic                 we,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [1 << pAddrBits];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/random_mstream.sv
// Wishbone slave exposing 2^pStreamBits independent MWC / xorshift32 streams,
// with per-stream z/w state in two block RAMs and a hardware seeding sweep.
module random_mstream
  import random_pkg::*;
#(
  parameter int          pStreamBits = 10,
  parameter logic [31:0] pInitZ      = 32'd17,
  parameter logic [31:0] pInitW      = 32'd3,
  parameter logic [15:0] pMulZ       = 16'd36969,
  parameter logic [15:0] pMulW       = 16'd18000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        busy_o
);

  state_t state_reg, state_next;

  logic [pStreamBits-1:0] init_idx_reg, stream_reg, cmd_stream_reg;
  logic [1:0]  ctrl_reg;
  logic        busy_reg, ack_reg, cmd_we_reg, adv_reg;
  logic [2:0]  cmd_sel_reg;
  logic [31:0] cmd_dat_reg, dat_reg, rd_val_reg, z_adv_reg, w_adv_reg;

  logic [pStreamBits-1:0] ram_addr;
  logic        z_we, w_we, req, reinit;
  logic [31:0] z_wdata, w_wdata, z_rd, w_rd;
  logic [31:0] out_val, z_step, w_step, rd_val;
  logic        adv;
  logic        unused_adr_bits;

  assign req             = cs_i & cyc_i & stb_i;
  assign reinit          = cmd_we_reg && (cmd_sel_reg == REG_CTRL) && cmd_dat_reg[CTRL_REINIT];
  assign unused_adr_bits = ^adr_i[1:0];
  assign ack_o           = ack_reg;
  assign dat_o           = dat_reg;
  assign busy_o          = busy_reg;

  rand_mstream_ram #(.pAddrBits(pStreamBits)) u_ram_z (
    .clk_i (clk_i), .addr (ram_addr), .we (z_we), .wdata (z_wdata), .rdata (z_rd)
  );

  rand_mstream_ram #(.pAddrBits(pStreamBits)) u_ram_w (
    .clk_i (clk_i), .addr (ram_addr), .we (w_we), .wdata (w_wdata), .rdata (w_rd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT:  if (&init_idx_reg) state_next = S_IDLE;
      S_IDLE:  if (req) state_next = S_RD;
      S_RD:    state_next = S_ACK;
      S_ACK:   state_next = reinit ? S_INIT : S_WAIT;
      S_WAIT:  if (!(stb_i && cs_i)) state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
  end

  // Output and next state are derived from the pre-advance RAM contents.
  always_comb begin
    out_val = ctrl_reg[CTRL_MODE] ? (z_rd ^ w_rd) : ({z_rd[15:0], 16'h0} + w_rd);
    z_step  = ctrl_reg[CTRL_MODE] ? xs32_step(z_rd) : mwc_step(z_rd, pMulZ);
    w_step  = ctrl_reg[CTRL_MODE] ? xs32_step(w_rd) : mwc_step(w_rd, pMulW);
    adv     = (cmd_sel_reg == REG_OUT) && (cmd_we_reg || ctrl_reg[CTRL_AUTO]);
    rd_val  = 32'd0;
    case (cmd_sel_reg)
      REG_OUT:  rd_val = out_val;
      REG_SEL:  rd_val = 32'(stream_reg);
      REG_Z:    rd_val = z_rd;
      REG_W:    rd_val = w_rd;
      REG_CTRL: rd_val = {30'd0, ctrl_reg};
      REG_STAT: rd_val = {31'd0, busy_reg};
      default:  rd_val = 32'd0;
    endcase
  end

  always_comb begin
    ram_addr = stream_reg;
    z_we     = 1'b0;
    w_we     = 1'b0;
    z_wdata  = z_adv_reg;
    w_wdata  = w_adv_reg;
    if (state_reg == S_INIT) begin
      ram_addr = init_idx_reg;
      z_we     = 1'b1;
      w_we     = 1'b1;
      z_wdata  = nonzero(pInitZ + 32'(init_idx_reg));
      w_wdata  = nonzero(pInitW + 32'(init_idx_reg));
    end else if (state_reg == S_ACK) begin
      ram_addr = cmd_stream_reg;
      if (adv_reg) begin
        z_we = 1'b1;
        w_we = 1'b1;
      end else if (cmd_we_reg && cmd_sel_reg == REG_Z) begin
        z_we    = 1'b1;
        z_wdata = nonzero(cmd_dat_reg);
      end else if (cmd_we_reg && cmd_sel_reg == REG_W) begin
        w_we    = 1'b1;
        w_wdata = nonzero(cmd_dat_reg);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_reg        <= 1'b0;
      dat_reg        <= 32'd0;
      stream_reg     <= '0;
      ctrl_reg       <= 2'd0;
      busy_reg       <= 1'b1;
      init_idx_reg   <= '0;
      cmd_stream_reg <= '0;
      cmd_we_reg     <= 1'b0;
      cmd_sel_reg    <= 3'd0;
      cmd_dat_reg    <= 32'd0;
      rd_val_reg     <= 32'd0;
      z_adv_reg      <= 32'd0;
      w_adv_reg      <= 32'd0;
      adv_reg        <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      dat_reg <= 32'd0;
      case (state_reg)
        S_INIT: begin
          init_idx_reg <= init_idx_reg + 1'b1;
          if (&init_idx_reg) busy_reg <= 1'b0;
        end
        S_IDLE: begin
          if (req) begin
            cmd_we_reg     <= we_i;
            cmd_sel_reg    <= adr_i[4:2];
            cmd_dat_reg    <= dat_i;
            cmd_stream_reg <= stream_reg;
          end
        end
        S_RD: begin
          rd_val_reg <= rd_val;
          z_adv_reg  <= z_step;
          w_adv_reg  <= w_step;
          adv_reg    <= adv;
        end
        S_ACK: begin
          ack_reg <= 1'b1;
          dat_reg <= rd_val_reg;
          if (cmd_we_reg && cmd_sel_reg == REG_SEL) stream_reg <= cmd_dat_reg[pStreamBits-1:0];
          if (cmd_we_reg && cmd_sel_reg == REG_CTRL) ctrl_reg <= cmd_dat_reg[1:0];
          if (reinit) busy_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_random_mstream.sv
// Directed bench for random_mstream: register-level vector table plus
// hand sequences for the init sweep, a held request and reset mid-transaction.
module tb_random_mstream;

  logic        clk_i = 1'b0;
  logic        rst_i, cs_i, cyc_i, stb_i, we_i;
  logic [4:0]  adr_i;
  logic [31:0] dat_i;
  logic        ack_o, busy_o;
  logic [31:0] dat_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  random_mstream dut (
    .clk_i (clk_i), .rst_i (rst_i), .cs_i (cs_i), .cyc_i (cyc_i), .stb_i (stb_i),
    .ack_o (ack_o), .we_i (we_i), .adr_i (adr_i), .dat_i (dat_i), .dat_o (dat_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [31:0] exp);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic bus_op(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                        output logic [31:0] rdata, output int cycles);
    logic ok;
    @(negedge clk_i);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
    cycles = 0; ok = 1'b0; rdata = 32'hx;
    while (cycles < 3000 && !ok) begin
      @(negedge clk_i);
      cycles++;
      if (ack_o) begin
        ok = 1'b1;
        rdata = dat_o;
      end
    end
    cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
    $display("txn we=%0b adr=%h dat=%h rdata=%h cycles=%0d", we, adr, dat, rdata, cycles);
  endtask

  task automatic wait_sweep(input string name);
    int cnt;
    cnt = 0;
    while (busy_o && cnt < 5000) begin
      cnt++;
      @(negedge clk_i);
    end
    chk(name, 32'(cnt), 32'd1024);
  endtask

  initial begin
    logic [31:0] rd;
    int cyc;

    rst_i = 1'b1; cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = 5'd0; dat_i = 32'd0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("reset_ack", {31'd0, ack_o}, 32'd0);
    chk("reset_dat", dat_o, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd1);
    wait_sweep("init_sweep_len");

    // {we, adr, dat, expected read}
    add_vec(0, 5'h00, 0, 32'h00110003);
    add_vec(1, 5'h04, 1, 0);
    add_vec(0, 5'h00, 0, 32'h00120004);
    add_vec(0, 5'h08, 0, 32'd18);
    add_vec(1, 5'h04, 32'h401, 0);
    add_vec(0, 5'h04, 0, 32'd1);
    add_vec(1, 5'h04, 0, 0);
    add_vec(1, 5'h00, 32'hFFFF_FFFF, 0);
    add_vec(0, 5'h00, 0, 32'h96F9D2F0);
    add_vec(0, 5'h08, 0, 32'h000996F9);
    add_vec(0, 5'h0C, 0, 32'h0000D2F0);
    add_vec(0, 5'h14, 0, 0);
    add_vec(0, 5'h18, 0, 0);
    add_vec(1, 5'h1C, 32'hDEAD_BEEF, 0);
    add_vec(0, 5'h1C, 0, 0);
    add_vec(0, 5'h10, 0, 0);
    add_vec(1, 5'h08, 32'd17, 0);
    add_vec(1, 5'h0C, 32'd3, 0);
    add_vec(1, 5'h10, 32'd1, 0);
    add_vec(0, 5'h10, 0, 32'd1);
    add_vec(1, 5'h00, 0, 0);
    add_vec(0, 5'h08, 0, 32'h00462210);
    add_vec(0, 5'h0C, 0, 32'h000C6063);
    add_vec(0, 5'h00, 0, 32'h004A4273);
    add_vec(1, 5'h08, 32'd17, 0);
    add_vec(1, 5'h0C, 32'd3, 0);
    add_vec(1, 5'h10, 32'd2, 0);
    add_vec(0, 5'h00, 0, 32'h00110003);
    add_vec(0, 5'h00, 0, 32'h96F9D2F0);
    add_vec(1, 5'h10, 32'd0, 0);
    add_vec(0, 5'h08, 0, 32'h5529FC2A);
    add_vec(1, 5'h08, 32'd0, 0);
    add_vec(0, 5'h08, 0, 32'd1);
    add_vec(1, 5'h0C, 32'd0, 0);
    add_vec(0, 5'h0C, 0, 32'd1);

    foreach (vecs[i]) begin
      bus_op(vecs[i].we, vecs[i].adr, vecs[i].dat, rd, cyc);
      if (!vecs[i].we) chk($sformatf("vec%0d_adr%h", i, vecs[i].adr), rd, vecs[i].exp);
    end

    @(negedge clk_i);
    chk("dat_idle_zero", dat_o, 32'd0);

    // Reinit by command; a request issued at once must wait out the sweep.
    bus_op(1'b1, 5'h10, 32'd4, rd, cyc);
    chk("reinit_busy", {31'd0, busy_o}, 32'd1);
    bus_op(1'b0, 5'h00, 32'd0, rd, cyc);
    chk("held_req_after_sweep", {31'd0, (cyc >= 1024)}, 32'd1);
    chk("held_req_busy", {31'd0, busy_o}, 32'd0);
    chk("held_req_data", rd, 32'h00110003);
    bus_op(1'b0, 5'h10, 32'd0, rd, cyc);
    chk("ctrl_reinit_reads0", rd, 32'd0);

    // Reset while the FSM sits in S_RD.
    @(negedge clk_i);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 5'h00;
    @(negedge clk_i);
    rst_i = 1'b1; cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_rd_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_rd_dat", dat_o, 32'd0);
    chk("rst_rd_busy", {31'd0, busy_o}, 32'd1);
    wait_sweep("rst_rd_sweep_len");
    bus_op(1'b0, 5'h00, 32'd0, rd, cyc);
    chk("post_rst_out", rd, 32'h00110003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
